// File: rtl/fifo_burst_drain_ctrl.sv
// Read-side burst sequencer for the 16-in/32-out frame-buffer FIFO: requests DDR write
// bursts once enough data is queued, then pops and streams exactly one burst of beats.
module fifo_burst_drain_ctrl #(
    parameter int DATA_W      = 32,
    parameter int LEVEL_W     = 12,
    parameter int ADDR_W      = 28,
    parameter int BURST_LEN   = 64,
    parameter int LEN_W       = 9,
    parameter int FRAME_WORDS = 393216,
    parameter int ADDR_BASE   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               flush,
    output logic               fifo_rd_en,
    input  logic [DATA_W-1:0]  fifo_rd_data,
    input  logic               fifo_rd_empty,
    input  logic [LEVEL_W-1:0] fifo_rd_water_level,
    output logic               bst_req,
    output logic [ADDR_W-1:0]  bst_addr,
    output logic [LEN_W-1:0]   bst_len,
    input  logic               bst_ack,
    output logic [DATA_W-1:0]  wdata,
    output logic               wdata_valid,
    input  logic               wdata_ready,
    output logic               busy,
    output logic               frame_done
);

    // state | meaning
    // IDLE  | waiting for a full burst (enable) or residual data (flush pending)
    // REQ   | bst_req high, address/length held until bst_ack
    // DATA  | popping the FIFO and streaming beats until all len beats are accepted
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam int FP_W  = $clog2(FRAME_WORDS + 1);
    localparam int FPX_W = FP_W + 1;
    localparam int CW0   = (FP_W > LEVEL_W) ? FP_W : LEVEL_W;
    localparam int CW    = ((CW0 > LEN_W) ? CW0 : LEN_W) + 1;

    logic [1:0]        state_q, state_d;
    logic [FP_W-1:0]   frame_pos_q, frame_pos_d;
    logic              flush_pending_q, flush_pending_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rd_left_q, rd_left_d;
    logic [LEN_W-1:0]  beats_left_q, beats_left_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        buf_cnt_q, buf_cnt_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;

    logic [CW-1:0]     frame_left_c;
    logic [CW-1:0]     len_full_c;
    logic [CW-1:0]     level_c;
    logic [CW-1:0]     part_len_c;
    logic [FPX_W-1:0]  frame_end_c;
    logic [2:0]        occ_c;
    logic              full_ok;
    logic              part_ok;
    logic              head_valid;
    logic              accept;
    logic              pop_head;
    logic              push;
    logic              rd_en;
    logic              last_beat;
    logic              end_of_frame;

    assign level_c      = CW'(fifo_rd_water_level);
    assign frame_left_c = CW'(FRAME_WORDS) - CW'(frame_pos_q);
    assign len_full_c   = (frame_left_c < CW'(BURST_LEN)) ? frame_left_c : CW'(BURST_LEN);
    assign part_len_c   = (level_c < len_full_c) ? level_c : len_full_c;
    assign full_ok      = enable && (level_c >= len_full_c);
    assign part_ok      = flush_pending_q && (level_c != '0);

    assign frame_end_c  = {1'b0, frame_pos_q} + FPX_W'(len_q);
    assign end_of_frame = (frame_end_c == FPX_W'(FRAME_WORDS));

    // Skid buffer head, or the word arriving from the FIFO when the buffer is empty,
    // so the first beat is visible in the cycle its read data returns.
    assign head_valid  = (buf_cnt_q != 2'd0);
    assign wdata_valid = head_valid || inflight_q;
    assign wdata       = head_valid ? buf0_q : (inflight_q ? fifo_rd_data : '0);
    assign accept      = wdata_valid && wdata_ready;
    assign pop_head    = accept && head_valid;
    assign push        = inflight_q && !(accept && !head_valid);

    // Occupancy left after this cycle's departure; a pop is allowed while it is below 2.
    assign occ_c = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, accept};
    assign rd_en = (state_q == ST_DATA) && (rd_left_q != '0) && !fifo_rd_empty
                   && (occ_c < 3'd2);

    assign last_beat  = (state_q == ST_DATA) && accept && (beats_left_q == LEN_W'(1));
    assign frame_done = last_beat && end_of_frame;

    assign fifo_rd_en = rd_en;
    assign bst_req    = (state_q == ST_REQ);
    assign bst_addr   = addr_q;
    assign bst_len    = len_q;
    assign busy       = (state_q != ST_IDLE) || head_valid || inflight_q;

    always_comb begin
        state_d         = state_q;
        frame_pos_d     = frame_pos_q;
        flush_pending_d = flush_pending_q;
        addr_d          = addr_q;
        len_d           = len_q;
        rd_left_d       = rd_left_q;
        beats_left_d    = beats_left_q;

        if (flush) begin
            flush_pending_d = 1'b1;
        end else if ((state_q == ST_IDLE) && (level_c == '0)) begin
            flush_pending_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (full_ok || part_ok) begin
                    state_d      = ST_REQ;
                    len_d        = full_ok ? LEN_W'(len_full_c) : LEN_W'(part_len_c);
                    addr_d       = ADDR_W'(ADDR_BASE) + ADDR_W'(frame_pos_q);
                    rd_left_d    = len_d;
                    beats_left_d = len_d;
                end
            end
            ST_REQ: begin
                if (bst_ack) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rd_en) begin
                    rd_left_d = rd_left_q - LEN_W'(1);
                end
                if (accept) begin
                    beats_left_d = beats_left_q - LEN_W'(1);
                end
                if (last_beat) begin
                    state_d     = ST_IDLE;
                    frame_pos_d = end_of_frame ? '0 : frame_pos_q + FP_W'(len_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        buf_cnt_d = buf_cnt_q;
        if (pop_head) begin
            buf0_d    = buf1_q;
            buf_cnt_d = buf_cnt_q - 2'd1;
        end
        if (push) begin
            if (buf_cnt_d == 2'd0) begin
                buf0_d = fifo_rd_data;
            end else begin
                buf1_d = fifo_rd_data;
            end
            buf_cnt_d = buf_cnt_d + 2'd1;
        end
    end

    assign inflight_d = rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            frame_pos_q     <= '0;
            flush_pending_q <= 1'b0;
            addr_q          <= ADDR_W'(ADDR_BASE);
            len_q           <= '0;
            rd_left_q       <= '0;
            beats_left_q    <= '0;
            inflight_q      <= 1'b0;
            buf_cnt_q       <= 2'd0;
            buf0_q          <= '0;
            buf1_q          <= '0;
        end else begin
            state_q         <= state_d;
            frame_pos_q     <= frame_pos_d;
            flush_pending_q <= flush_pending_d;
            addr_q          <= addr_d;
            len_q           <= len_d;
            rd_left_q       <= rd_left_d;
            beats_left_q    <= beats_left_d;
            inflight_q      <= inflight_d;
            buf_cnt_q       <= buf_cnt_d;
            buf0_q          <= buf0_d;
            buf1_q          <= buf1_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_drain_ctrl.sv
// Directed bench for fifo_burst_drain_ctrl with a behavioural read-side FIFO and a
// scoreboard of the words written into it.
module tb_fifo_burst_drain_ctrl;

    localparam int DW = 32;
    localparam int LW = 12;
    localparam int AW = 28;
    localparam int NW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          flush;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_empty;
    logic [LW-1:0] fifo_rd_water_level;
    logic          bst_req;
    logic [AW-1:0] bst_addr;
    logic [NW-1:0] bst_len;
    logic          bst_ack;
    logic [DW-1:0] wdata;
    logic          wdata_valid;
    logic          wdata_ready;
    logic          busy;
    logic          frame_done;

    fifo_burst_drain_ctrl #(
        .DATA_W(DW), .LEVEL_W(LW), .ADDR_W(AW), .BURST_LEN(64), .LEN_W(NW),
        .FRAME_WORDS(256), .ADDR_BASE('h100)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty), .fifo_rd_water_level(fifo_rd_water_level),
        .bst_req(bst_req), .bst_addr(bst_addr), .bst_len(bst_len), .bst_ack(bst_ack),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] wr_val = 32'd65535;
    int  wr_per_cycle = 0;
    bit  rdy_rand = 1'b0;
    bit  pop_s = 1'b0;
    int  req_cyc = 0;
    int  req_starts, acks, beats, data_errs, empty_pops, stab_errs, fd_bad;
    logic [AW-1:0] addr_log[$];
    logic [NW-1:0] len_log[$];
    int  fd_log[$];
    logic [AW-1:0] first_addr;
    logic [NW-1:0] first_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word();
        fifo_q.push_back(wr_val);
        exp_q.push_back(wr_val);
        wr_val = wr_val - 32'd1;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) push_word();
    endtask

    task automatic clear_logs();
        req_starts = 0; acks = 0; beats = 0; data_errs = 0;
        empty_pops = 0; stab_errs = 0; fd_bad = 0;
        addr_log.delete(); len_log.delete(); fd_log.delete();
    endtask

    // One clock: FIFO model and responders update at the negedge, outputs are sampled 2ns later.
    task automatic step();
        bit rst_s;
        logic [DW-1:0] exp_w;
        rst_s = rst;
        @(negedge clk);
        if (rst_s) begin
            fifo_q.delete();
            fifo_rd_data = '0;
        end else if (pop_s) begin
            if (fifo_q.size() != 0) fifo_rd_data = fifo_q.pop_front();
            else empty_pops++;
        end
        pop_s = 1'b0;
        if (wr_per_cycle > 0) begin
            push_word();
            wr_per_cycle--;
        end
        fifo_rd_water_level = LW'(fifo_q.size());
        fifo_rd_empty       = (fifo_q.size() == 0);
        if (bst_req) begin
            req_cyc++;
            bst_ack = (req_cyc == 3);
        end else begin
            req_cyc = 0;
            bst_ack = 1'b0;
        end
        wdata_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #2;
        if (fifo_rd_en && fifo_rd_empty) empty_pops++;
        if (bst_req) begin
            if (req_cyc == 1) begin
                req_starts++;
                first_addr = bst_addr;
                first_len  = bst_len;
            end else if (bst_addr !== first_addr || bst_len !== first_len) begin
                stab_errs++;
            end
            if (bst_ack) begin
                acks++;
                addr_log.push_back(bst_addr);
                len_log.push_back(bst_len);
            end
        end
        if (wdata_valid && wdata_ready) begin
            beats++;
            if (exp_q.size() == 0) data_errs++;
            else begin
                exp_w = exp_q.pop_front();
                if (wdata !== exp_w) data_errs++;
            end
            if (frame_done) fd_log.push_back(beats);
        end else if (frame_done) begin
            fd_bad++;
        end
        pop_s = fifo_rd_en;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; flush = 1'b0; bst_ack = 1'b0; wdata_ready = 1'b1;
        fifo_rd_data = '0; fifo_rd_empty = 1'b1; fifo_rd_water_level = '0;
        clear_logs();
        repeat (3) step();
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_req", 32'(bst_req), 0);
        chk("rst_addr", 32'(bst_addr), 32'h100);
        chk("rst_len", 32'(bst_len), 0);
        chk("rst_valid", 32'(wdata_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        // 1: two full bursts from 200 words, enable dropped after the second grant
        clear_logs();
        enable = 1'b1;
        fill(200);
        for (int i = 0; i < 400 && acks < 2; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 400 && beats < 128; i++) step();
        repeat (40) step();
        chk("t1_reqs", 32'(req_starts), 2);
        chk("t1_addr0", 32'(addr_log[0]), 32'h100);
        chk("t1_len0", 32'(len_log[0]), 64);
        chk("t1_addr1", 32'(addr_log[1]), 32'h140);
        chk("t1_len1", 32'(len_log[1]), 64);
        chk("t1_beats", 32'(beats), 128);
        chk("t1_data", 32'(data_errs), 0);
        chk("t1_level", 32'(fifo_rd_water_level), 72);
        chk("t1_fd", 32'(fd_log.size()), 0);
        chk("t1_busy", 32'(busy), 0);

        // 2: continuous fill across two frames
        do_reset();
        enable = 1'b1;
        wr_per_cycle = 512;
        for (int i = 0; i < 3000 && beats < 512; i++) step();
        repeat (10) step();
        enable = 1'b0;
        chk("t2_beats", 32'(beats), 512);
        chk("t2_reqs", 32'(req_starts), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_addr%0d", i), 32'(addr_log[i]), 32'h100 + 32'(64 * (i % 4)));
        chk("t2_fd_n", 32'(fd_log.size()), 2);
        chk("t2_fd0", 32'(fd_log[0]), 256);
        chk("t2_fd1", 32'(fd_log[1]), 512);
        chk("t2_fd_bad", 32'(fd_bad), 0);
        chk("t2_data", 32'(data_errs), 0);
        chk("t2_empty", 32'(empty_pops), 0);
        chk("t2_stab", 32'(stab_errs), 0);

        // 3: flush drains a 40-word residue; a flush on an empty FIFO requests nothing
        clear_logs();
        fill(40);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 300 && beats < 40; i++) step();
        repeat (20) step();
        chk("t3_reqs", 32'(req_starts), 1);
        chk("t3_addr", 32'(addr_log[0]), 32'h100);
        chk("t3_len", 32'(len_log[0]), 40);
        chk("t3_beats", 32'(beats), 40);
        chk("t3_data", 32'(data_errs), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (30) step();
        fill(10);
        repeat (30) step();
        chk("t3_noreq", 32'(req_starts), 1);
        chk("t3_level", 32'(fifo_rd_water_level), 10);

        // 4: one burst under random backpressure
        clear_logs();
        fill(54);
        enable = 1'b1;
        rdy_rand = 1'b1;
        for (int i = 0; i < 1000 && beats < 64; i++) step();
        rdy_rand = 1'b0;
        repeat (20) step();
        enable = 1'b0;
        chk("t4_reqs", 32'(req_starts), 1);
        chk("t4_addr", 32'(addr_log[0]), 32'h128);
        chk("t4_len", 32'(len_log[0]), 64);
        chk("t4_beats", 32'(beats), 64);
        chk("t4_data", 32'(data_errs), 0);
        chk("t4_empty", 32'(empty_pops), 0);
        chk("t4_level", 32'(fifo_rd_water_level), 0);
        chk("t4_busy", 32'(busy), 0);

        // 5: reset at beat 20 of a burst
        clear_logs();
        fill(64);
        enable = 1'b1;
        for (int i = 0; i < 300 && beats < 20; i++) step();
        chk("t5_addr_pre", 32'(addr_log[0]), 32'h168);
        chk("t5_beats_pre", 32'(beats), 20);
        do_reset();
        chk("t5_rd_en", 32'(fifo_rd_en), 0);
        chk("t5_req", 32'(bst_req), 0);
        chk("t5_addr", 32'(bst_addr), 32'h100);
        chk("t5_len", 32'(bst_len), 0);
        chk("t5_wdata", wdata, 0);
        chk("t5_valid", 32'(wdata_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_fd", 32'(frame_done), 0);
        fill(64);
        for (int i = 0; i < 300 && beats < 64; i++) step();
        repeat (5) step();
        enable = 1'b0;
        chk("t5_post_addr", 32'(addr_log[0]), 32'h100);
        chk("t5_post_beats", 32'(beats), 64);
        chk("t5_post_data", 32'(data_errs), 0);

        // 6: enable dropped while requesting and again mid-burst
        clear_logs();
        fill(128);
        enable = 1'b1;
        for (int i = 0; i < 20 && req_starts < 1; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 20 && acks < 1; i++) step();
        enable = 1'b1;
        for (int i = 0; i < 100 && beats < 30; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 200 && beats < 64; i++) step();
        repeat (40) step();
        chk("t6_reqs", 32'(req_starts), 1);
        chk("t6_addr", 32'(addr_log[0]), 32'h140);
        chk("t6_len", 32'(len_log[0]), 64);
        chk("t6_beats", 32'(beats), 64);
        chk("t6_data", 32'(data_errs), 0);
        chk("t6_level", 32'(fifo_rd_water_level), 64);
        chk("t6_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
